// File: rtl/alu_exec_if.sv
// Request/result bundle between an issuing stage and the alu_exec execute unit.
// valid/ready contract: start is honoured only on an edge where busy=0; a start while busy=1 is dropped, never queued.
interface alu_exec_if #(
   parameter int WIDTH   = 32,
   parameter int REGADDR = 2
);
   logic               start;
   logic [2:0]         op;
   logic [REGADDR-1:0] dest;
   logic [WIDTH-1:0]   srca;
   logic [WIDTH-1:0]   srcb;
   logic               busy;
   logic               done;
   logic               regwrite;
   logic [REGADDR-1:0] writereg;
   logic [WIDTH-1:0]   writedata;
   logic               err;
   logic               dbg_state;

   modport master (
      output start, op, dest, srca, srcb,
      input  busy, done, regwrite, writereg, writedata, err, dbg_state
   );

   modport slave (
      input  start, op, dest, srca, srcb,
      output busy, done, regwrite, writereg, writedata, err, dbg_state
   );
endinterface

// File: rtl/alu_exec.sv
// Execute unit: single-cycle ADD/SUB/AND/OR/SLT and a WIDTH-cycle shift-add multiply.
// Every output is a register; dbg_state mirrors the FSM state (0=IDLE, 1=MUL).
module alu_exec #(
   parameter int WIDTH   = 32,
   parameter int REGADDR = 2
) (
   input  logic       clock,
   input  logic       reset,
   alu_exec_if.slave  bus
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic {ST_IDLE = 1'b0, ST_MUL = 1'b1} state_t;

   state_t             r_state;
   logic [CW-1:0]      r_count;
   logic [WIDTH-1:0]   r_acc;
   logic [WIDTH-1:0]   r_mcand;
   logic [WIDTH-1:0]   r_mplier;
   logic [REGADDR-1:0] r_dest;
   logic               r_busy;
   logic               r_done;
   logic               r_regwrite;
   logic               r_err;
   logic [REGADDR-1:0] r_writereg;
   logic [WIDTH-1:0]   r_writedata;

   logic [WIDTH-1:0]   w_alu;
   logic [WIDTH-1:0]   w_acc_next;

   always_comb begin
      w_alu = '0;
      case (bus.op)
         3'b000:  w_alu = bus.srca + bus.srcb;
         3'b001:  w_alu = bus.srca - bus.srcb;
         3'b010:  w_alu = bus.srca & bus.srcb;
         3'b011:  w_alu = bus.srca | bus.srcb;
         3'b100:  w_alu = {{(WIDTH-1){1'b0}}, ($signed(bus.srca) < $signed(bus.srcb))};
         default: w_alu = '0;
      endcase
   end

   assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_count     <= '0;
         r_acc       <= '0;
         r_mcand     <= '0;
         r_mplier    <= '0;
         r_dest      <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_regwrite  <= 1'b0;
         r_err       <= 1'b0;
         r_writereg  <= '0;
         r_writedata <= '0;
      end else begin
         r_done     <= 1'b0;
         r_regwrite <= 1'b0;
         r_err      <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (bus.start) begin
                  case (bus.op)
                     3'b000, 3'b001, 3'b010, 3'b011, 3'b100: begin
                        r_writedata <= w_alu;
                        r_writereg  <= bus.dest;
                        r_done      <= 1'b1;
                        r_regwrite  <= 1'b1;
                     end
                     3'b101: begin
                        r_state  <= ST_MUL;
                        r_busy   <= 1'b1;
                        r_acc    <= '0;
                        r_mcand  <= bus.srca;
                        r_mplier <= bus.srcb;
                        r_count  <= '0;
                        r_dest   <= bus.dest;
                     end
                     default: begin
                        r_err  <= 1'b1;
                        r_done <= 1'b1;
                     end
                  endcase
               end
            end
            ST_MUL: begin
               r_acc    <= w_acc_next;
               r_mcand  <= r_mcand << 1;
               r_mplier <= r_mplier >> 1;
               r_count  <= r_count + 1'b1;
               // Last step: the final partial product goes straight to writedata.
               if (r_count == CW'(WIDTH-1)) begin
                  r_state     <= ST_IDLE;
                  r_busy      <= 1'b0;
                  r_done      <= 1'b1;
                  r_regwrite  <= 1'b1;
                  r_writedata <= w_acc_next;
                  r_writereg  <= r_dest;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign bus.busy      = r_busy;
   assign bus.done      = r_done;
   assign bus.regwrite  = r_regwrite;
   assign bus.err       = r_err;
   assign bus.writereg  = r_writereg;
   assign bus.writedata = r_writedata;
   assign bus.dbg_state = r_state;
endmodule

// File: tb/tb_alu_exec.sv
// Randomized and directed bench for alu_exec against a cycle-timed transaction model.
module tb_alu_exec;
   localparam int W = 32;
   localparam int RA = 2;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   alu_exec_if #(.WIDTH(W), .REGADDR(RA)) bus ();

   alu_exec #(.WIDTH(W), .REGADDR(RA)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.slave)
   );

   int checks = 0;
   int failures = 0;

   // Model state: outstanding multiply cycles and its precomputed result.
   int            mul_left;
   logic [W-1:0]  mul_res;
   logic [RA-1:0] mul_dest;
   logic          e_busy, e_done, e_rw, e_err;
   logic [RA-1:0] e_wr;
   logic [W-1:0]  e_wd;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_edge(input logic rst, input logic st, input logic [2:0] o,
                             input logic [RA-1:0] d, input logic [W-1:0] a, input logic [W-1:0] b);
      logic [63:0] prod;
      if (rst) begin
         mul_left = 0;
         e_busy = 0; e_done = 0; e_rw = 0; e_err = 0; e_wr = '0; e_wd = '0;
         return;
      end
      e_done = 0; e_rw = 0; e_err = 0;
      if (mul_left > 0) begin
         mul_left--;
         if (mul_left == 0) begin
            e_busy = 0; e_done = 1; e_rw = 1; e_wd = mul_res; e_wr = mul_dest;
         end
      end else if (st) begin
         case (o)
            3'd0: begin e_wd = a + b; e_wr = d; e_done = 1; e_rw = 1; end
            3'd1: begin e_wd = a - b; e_wr = d; e_done = 1; e_rw = 1; end
            3'd2: begin e_wd = a & b; e_wr = d; e_done = 1; e_rw = 1; end
            3'd3: begin e_wd = a | b; e_wr = d; e_done = 1; e_rw = 1; end
            3'd4: begin e_wd = ($signed(a) < $signed(b)) ? 1 : 0; e_wr = d; e_done = 1; e_rw = 1; end
            3'd5: begin
               prod = {32'd0, a} * {32'd0, b};
               mul_res = prod[W-1:0]; mul_dest = d; mul_left = W; e_busy = 1;
            end
            default: begin e_err = 1; e_done = 1; end
         endcase
      end
   endtask

   task automatic step(input logic rst, input logic st, input logic [2:0] o,
                       input logic [RA-1:0] d, input logic [W-1:0] a, input logic [W-1:0] b);
      @(negedge clock);
      reset = rst; bus.start = st; bus.op = o; bus.dest = d; bus.srca = a; bus.srcb = b;
      @(posedge clock);
      model_edge(rst, st, o, d, a, b);
      #1;
      check_eq("busy", bus.busy, e_busy);
      check_eq("done", bus.done, e_done);
      check_eq("regwrite", bus.regwrite, e_rw);
      check_eq("err", bus.err, e_err);
      check_eq("writereg", bus.writereg, e_wr);
      check_eq("writedata", bus.writedata, e_wd);
      check_eq("dbg_state", bus.dbg_state, (mul_left > 0) ? 1'b1 : 1'b0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 3'd0, '0, '0, '0);
   endtask

   function automatic logic [W-1:0] rand_operand();
      case ($urandom_range(0, 5))
         0: return 32'h0000_0000;
         1: return 32'hFFFF_FFFF;
         2: return 32'h7FFF_FFFF;
         3: return 32'h8000_0000;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      bus.start = 0; bus.op = '0; bus.dest = '0; bus.srca = '0; bus.srcb = '0;
      mul_left = 0;
      step(1, 1, 3'd0, 2'd3, 32'h1, 32'h1);
      step(1, 0, 3'd0, '0, '0, '0);

      // Wrapping add.
      step(0, 1, 3'd0, 2'd1, 32'h7FFF_FFFF, 32'h0000_0001);
      check_eq("add_const", bus.writedata, 32'h8000_0000);
      idle(1);

      // SUB, SLT, SLT back to back.
      step(0, 1, 3'd1, 2'd0, 32'h0, 32'h1);
      check_eq("sub_const", bus.writedata, 32'hFFFF_FFFF);
      step(0, 1, 3'd4, 2'd2, 32'hFFFF_FFFF, 32'h1);
      check_eq("slt_neg", bus.writedata, 32'h1);
      step(0, 1, 3'd4, 2'd3, 32'h1, 32'hFFFF_FFFF);
      check_eq("slt_pos", bus.writedata, 32'h0);
      idle(1);

      // Multiply with start re-pulsed and operands disturbed mid-flight.
      step(0, 1, 3'd5, 2'd2, 32'h0001_0003, 32'h0000_0005);
      for (int i = 0; i < W; i++)
         step(0, (i % 3) == 0, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), $urandom, $urandom);
      check_eq("mul_const", bus.writedata, 32'h0005_000F);

      // Request on the multiply's done cycle, then overflowing and zero products.
      step(0, 1, 3'd5, 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      idle(W);
      check_eq("mul_ff", bus.writedata, 32'h1);
      step(0, 1, 3'd5, 2'd0, 32'h1234_5678, 32'h0);
      idle(W);
      check_eq("mul_zero", bus.writedata, 32'h0);

      // Reset aborts a multiply on its 10th cycle.
      step(0, 1, 3'd5, 2'd3, 32'hDEAD_BEEF, 32'h0000_0123);
      idle(9);
      step(1, 1, 3'd5, 2'd3, 32'h1, 32'h1);
      step(0, 1, 3'd2, 2'd1, 32'hF0F0_F0F0, 32'hFF00_FF00);
      check_eq("and_const", bus.writedata, 32'hF000_F000);
      idle(W + 2);

      // Illegal opcode keeps the previous result.
      step(0, 1, 3'd3, 2'd2, 32'h0000_00A0, 32'h0000_000B);
      step(0, 1, 3'd6, 2'd0, 32'h1, 32'h2);
      check_eq("illegal_hold", bus.writedata, 32'h0000_00AB);
      step(0, 1, 3'd7, 2'd1, 32'h3, 32'h4);

      // Random traffic, multiplies weighted down to keep the run short.
      for (int i = 0; i < 600; i++) begin
         logic [2:0] o;
         o = ($urandom_range(0, 9) == 0) ? 3'd5 : 3'($urandom_range(0, 7));
         if (o == 3'd5 && $urandom_range(0, 2) != 0) o = 3'd0;
         step($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 7, o,
              2'($urandom_range(0, 3)), rand_operand(), rand_operand());
      end
      idle(W + 2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
